cla_slice_sequencer: RTL and testbench

- Multi-cycle wide adder front-end that time-multiplexes one external SLICE_W-bit carry-lookahead adder slice over NUM_SLICES chunks.
- Feeds the slice its operand chunks and carry-in, then consumes the slice's sum, group-propagate and group-generate outputs.
- Chains the carry through a register and assembles the full-width sum and carry-out.
- Sits directly upstream of, and wraps around, the slice: it produces the slice's a, b and carry inputs and consumes its s, p and g outputs.

---
 rtl/cla_slice_sequencer.sv | 111 +++++++++++
 tb/tb_cla_slice_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cla_slice_sequencer.sv
// Multi-cycle wide adder: time-multiplexes one external carry-lookahead slice
// over NUM_SLICES chunks, chaining the carry through a register.
module cla_slice_sequencer #(
  parameter  int SLICE_W    = 3,
  parameter  int NUM_SLICES = 4,
  localparam int W          = SLICE_W * NUM_SLICES
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_in_valid,
  output logic               io_in_ready,
  input  logic [W-1:0]       io_in_a,
  input  logic [W-1:0]       io_in_b,
  input  logic               io_in_cin,
  output logic               io_out_valid,
  input  logic               io_out_ready,
  output logic [W-1:0]       io_out_sum,
  output logic               io_out_cout,
  output logic [SLICE_W-1:0] io_slice_a,
  output logic [SLICE_W-1:0] io_slice_b,
  output logic               io_slice_carry,
  input  logic [SLICE_W-1:0] io_slice_s,
  input  logic               io_slice_p,
  input  logic               io_slice_g
);

  localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                                state_q, state_d;
  logic [IDX_W-1:0]                      idx_q, idx_d;
  logic [NUM_SLICES-1:0][SLICE_W-1:0]    a_q, a_d;
  logic [NUM_SLICES-1:0][SLICE_W-1:0]    b_q, b_d;
  logic [NUM_SLICES-1:0][SLICE_W-1:0]    sum_q, sum_d;
  logic                                  carry_q, carry_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  // NOTE: every signal written below gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    a_d            = a_q;
    b_d            = b_q;
    sum_d          = sum_q;
    carry_d        = carry_q;
    io_in_ready    = 1'b0;
    io_out_valid   = 1'b0;
    io_out_sum     = '0;
    io_out_cout    = 1'b0;
    io_slice_a     = '0;
    io_slice_b     = '0;
    io_slice_carry = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Reset gates ready directly so nothing is accepted while it is held.
        io_in_ready = ~reset;
        if (io_in_valid && io_in_ready) begin
          a_d     = io_in_a;
          b_d     = io_in_b;
          carry_d = io_in_cin;
          sum_d   = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        io_slice_a     = a_q[idx_q];
        io_slice_b     = b_q[idx_q];
        io_slice_carry = carry_q;
        sum_d[idx_q]   = io_slice_s;
        carry_d        = io_slice_g | (io_slice_p & carry_q);
        idx_d          = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        io_out_valid = 1'b1;
        io_out_sum   = sum_q;
        io_out_cout  = carry_q;
        if (io_out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cla_slice_sequencer.sv
// Self-checking bench: behavioural adder slice plus an arithmetic reference
// model for the full-width sum and per-chunk slice traffic.
module tb_cla_slice_sequencer;

  localparam int SLICE_W    = 3;
  localparam int NUM_SLICES = 4;
  localparam int W          = SLICE_W * NUM_SLICES;

  logic               clock = 1'b0;
  logic               reset;
  logic               io_in_valid;
  logic               io_in_ready;
  logic [W-1:0]       io_in_a;
  logic [W-1:0]       io_in_b;
  logic               io_in_cin;
  logic               io_out_valid;
  logic               io_out_ready;
  logic [W-1:0]       io_out_sum;
  logic               io_out_cout;
  logic [SLICE_W-1:0] io_slice_a;
  logic [SLICE_W-1:0] io_slice_b;
  logic               io_slice_carry;
  logic [SLICE_W-1:0] io_slice_s;
  logic               io_slice_p;
  logic               io_slice_g;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  // External slice: plain sum, generate = carry-out with zero carry-in,
  // OR-form propagate = every bit position can pass a carry.
  logic [SLICE_W:0] ab_sum, abc_sum;
  assign ab_sum     = {1'b0, io_slice_a} + {1'b0, io_slice_b};
  assign abc_sum    = ab_sum + {{SLICE_W{1'b0}}, io_slice_carry};
  assign io_slice_s = abc_sum[SLICE_W-1:0];
  assign io_slice_g = ab_sum[SLICE_W];
  assign io_slice_p = &(io_slice_a | io_slice_b);

  cla_slice_sequencer #(.SLICE_W(SLICE_W), .NUM_SLICES(NUM_SLICES)) dut (
    .clock          (clock),
    .reset          (reset),
    .io_in_valid    (io_in_valid),
    .io_in_ready    (io_in_ready),
    .io_in_a        (io_in_a),
    .io_in_b        (io_in_b),
    .io_in_cin      (io_in_cin),
    .io_out_valid   (io_out_valid),
    .io_out_ready   (io_out_ready),
    .io_out_sum     (io_out_sum),
    .io_out_cout    (io_out_cout),
    .io_slice_a     (io_slice_a),
    .io_slice_b     (io_slice_b),
    .io_slice_carry (io_slice_carry),
    .io_slice_s     (io_slice_s),
    .io_slice_p     (io_slice_p),
    .io_slice_g     (io_slice_g)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(io_in_ready), 0);
    check({tag, "_out_valid"}, 32'(io_out_valid), 0);
    check({tag, "_out_sum"}, 32'(io_out_sum), 0);
    check({tag, "_out_cout"}, 32'(io_out_cout), 0);
    check({tag, "_slice_a"}, 32'(io_slice_a), 0);
    check({tag, "_slice_b"}, 32'(io_slice_b), 0);
    check({tag, "_slice_carry"}, 32'(io_slice_carry), 0);
  endtask

  // Starts and ends at a negedge with the DUT in IDLE. hold = extra DONE
  // cycles with io_out_ready low; poke drives a foreign request during RUN.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input int hold, input bit poke);
    int ai, bi, full, mask_k, chunk_mask;
    ai = int'(a);
    bi = int'(b);
    full = ai + bi + int'(cin);
    chunk_mask = (1 << SLICE_W) - 1;

    check("idle_ready", 32'(io_in_ready), 1);
    io_in_valid = 1'b1;
    io_in_a     = a;
    io_in_b     = b;
    io_in_cin   = cin;
    @(negedge clock);
    if (poke) begin
      io_in_a   = 12'hAAA;
      io_in_b   = 12'h555;
      io_in_cin = 1'b1;
    end else begin
      io_in_valid = 1'b0;
    end

    for (int k = 0; k < NUM_SLICES; k++) begin
      mask_k = (1 << (k * SLICE_W)) - 1;
      check("run_slice_a", 32'(io_slice_a), 32'((ai >> (k * SLICE_W)) & chunk_mask));
      check("run_slice_b", 32'(io_slice_b), 32'((bi >> (k * SLICE_W)) & chunk_mask));
      check("run_slice_carry", 32'(io_slice_carry),
            32'(((ai & mask_k) + (bi & mask_k) + int'(cin)) >> (k * SLICE_W)));
      check("run_in_ready", 32'(io_in_ready), 0);
      check("run_out_valid", 32'(io_out_valid), 0);
      @(negedge clock);
    end
    io_in_valid = 1'b0;

    for (int h = 0; h <= hold; h++) begin
      check("done_valid", 32'(io_out_valid), 1);
      check("done_sum", 32'(io_out_sum), 32'(full & ((1 << W) - 1)));
      check("done_cout", 32'(io_out_cout), 32'((full >> W) & 1));
      check("done_in_ready", 32'(io_in_ready), 0);
      check("done_slice_a", 32'(io_slice_a), 0);
      if (h == hold) io_out_ready = 1'b1;
      @(negedge clock);
    end
    io_out_ready = 1'b0;
    check("back_idle_valid", 32'(io_out_valid), 0);
    check("back_idle_sum", 32'(io_out_sum), 0);
    check("back_idle_ready", 32'(io_in_ready), 1);
  endtask

  initial begin
    reset        = 1'b1;
    io_in_valid  = 1'b0;
    io_in_a      = '0;
    io_in_b      = '0;
    io_in_cin    = 1'b0;
    io_out_ready = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clock);
    check_all_zero("reset_held");
    reset = 1'b0;
    @(negedge clock);

    run_op(12'h123, 12'h456, 1'b0, 0, 1'b0);
    run_op(12'hFFF, 12'h001, 1'b0, 0, 1'b0);
    run_op(12'h7FF, 12'h800, 1'b1, 0, 1'b0);
    run_op(12'h000, 12'h000, 1'b1, 0, 1'b0);
    // Backpressure, then a back-to-back request the cycle after IDLE returns.
    run_op(12'hABC, 12'h987, 1'b1, 5, 1'b0);
    run_op(12'h001, 12'h001, 1'b0, 0, 1'b1);

    // Abort mid-RUN: reset lands during the second RUN cycle.
    io_in_valid = 1'b1;
    io_in_a     = 12'h555;
    io_in_b     = 12'h333;
    io_in_cin   = 1'b0;
    @(negedge clock);
    io_in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_all_zero("abort");
    @(negedge clock);
    check_all_zero("abort_held");
    reset = 1'b0;
    #1;
    check("abort_release_ready", 32'(io_in_ready), 1);
    check("abort_release_valid", 32'(io_out_valid), 0);
    @(negedge clock);
    run_op(12'h100, 12'h0FF, 1'b0, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
             bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
